// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial addition controller wrapped around an external, purely
//   combinational 1-bit full-adder cell. It latches two WIDTH-bit operands
//   and a carry-in, presents one bit pair per clock (LSB first), registers
//   the cell's carry between bits, and shifts the cell's sum bits into a
//   result register. A one-cycle done pulse marks a completed result.
//
//   Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed
//   overflow flag (port ovf).
//
// Parameters
//   WIDTH    operand width, 1..32
// Ports
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request a new addition (accepted in IDLE and DONE)
//   a, b     operands, sampled on the accepting edge
//   cin      carry-in, sampled on the accepting edge
//   busy     high while bits are being processed (RUN)
//   done     one-cycle pulse, sum/cout(/ovf) valid
//   sum      result, held until the next completed addition
//   cout     final carry-out, held like sum
//   ovf      signed overflow (only with SERIAL_ADD_OVF_EN)
//   cell_a   -> cell a_i
//   cell_b   -> cell b_i
//   cell_c   -> cell c_i
//   cell_s   <- cell s_i
//   cell_co  <- cell c_iplus1
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             cell_a,
   output logic             cell_b,
   output logic             cell_c,
   input  logic             cell_s,
   input  logic             cell_co
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             last_bit;

   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic             c_r;
   logic [CW-1:0]    cnt;

   // {new bit, old shift reg} >> 1; written as a wide slice so WIDTH == 1
   // needs no special case.
   logic [WIDTH:0]   sum_cat;
   logic [WIDTH-1:0] sum_nxt;

   assign sum_cat = {cell_s, sum_sh};
   assign sum_nxt = sum_cat[WIDTH:1];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: a running
            // addition cannot be interrupted or restarted.
            if (cnt == LAST) begin
               last_bit  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Cell inputs are forced low outside RUN so the cell sees quiet inputs.
   assign cell_a = busy & a_sh[0];
   assign cell_b = busy & b_sh[0];
   assign cell_c = busy & c_r;

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c_r    <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         c_r  <= cin;
         cnt  <= '0;
      end else if (state == RUN) begin
         sum_sh <= sum_nxt;
         c_r    <= cell_co;
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   // Results only move on the final RUN edge, so a new start cannot
   // disturb the previously reported value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (last_bit) begin
         sum  <= sum_nxt;
         cout <= cell_co;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // On the last bit c_r is the carry into the MSB; overflow is that carry
   // differing from the carry out of the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ovf <= 1'b0;
      else if (last_bit) ovf <= c_r ^ cell_co;
   end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   logic         cell_a, cell_b, cell_c, cell_s, cell_co;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   // WIDTH = 1 instance
   logic         start1 = 1'b0;
   logic [0:0]   a1 = '0, b1 = '0;
   logic         cin1 = 1'b0;
   logic         busy1, done1, cout1;
   logic [0:0]   sum1;
   logic         c1_a, c1_b, c1_c, c1_s, c1_co;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural full-adder cells
   assign cell_s  = cell_a ^ cell_b ^ cell_c;
   assign cell_co = (cell_a & cell_b) | (cell_a & cell_c) | (cell_b & cell_c);
   assign c1_s    = c1_a ^ c1_b ^ c1_c;
   assign c1_co   = (c1_a & c1_b) | (c1_a & c1_c) | (c1_b & c1_c);

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout),
`ifdef SERIAL_ADD_OVF_EN
      .ovf(ovf),
`endif
      .cell_a(cell_a), .cell_b(cell_b), .cell_c(cell_c),
      .cell_s(cell_s), .cell_co(cell_co)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
`ifdef SERIAL_ADD_OVF_EN
      .ovf(ovf1),
`endif
      .cell_a(c1_a), .cell_b(c1_b), .cell_c(c1_c),
      .cell_s(c1_s), .cell_co(c1_co)
   );

   task automatic test_reset();
      #2;
      checks++;
      if ({busy, done, sum, cout, cell_a, cell_b, cell_c} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b cells=%b%b%b want all 0",
                  busy, done, sum, cout, cell_a, cell_b, cell_c);
      end
      checks++;
      if ({busy1, done1, sum1, cout1, c1_a, c1_b, c1_c} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_w1 got %b want 0",
                  {busy1, done1, sum1, cout1, c1_a, c1_b, c1_c});
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if ({ovf, ovf1} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ovf got %b want 00", {ovf, ovf1});
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One complete addition with latency, busy length, single done pulse,
   // quiet cells in DONE and held result checked against plain arithmetic.
   task automatic test_add(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                           input logic tc, input string nm);
      logic [W:0]   r;
      int           sa, done_at, busy_cnt, n_done;
      logic [W-1:0] s_at;
      logic         c_at, o_at, exp_ovf;
      logic [2:0]   cells_at;
      r  = (W+1)'(ta) + (W+1)'(tbv) + (W+1)'(tc);
      sa = int'($signed(ta)) + int'($signed(tbv)) + int'(tc);
      exp_ovf = (sa > 127) || (sa < -128);
      @(negedge clk);
      start = 1'b1; a = ta; b = tbv; cin = tc;
      @(posedge clk); #1;
      // Scramble inputs to show the operands were latched.
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      done_at = 0; busy_cnt = 0; n_done = 0;
      s_at = '0; c_at = 1'b0; o_at = 1'b0; cells_at = '0;
      for (int i = 1; i <= W + 6; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            n_done++;
            if (done_at == 0) begin
               done_at  = i;
               s_at     = sum;
               c_at     = cout;
               cells_at = {cell_a, cell_b, cell_c};
`ifdef SERIAL_ADD_OVF_EN
               o_at     = ovf;
`endif
            end
         end
      end
      checks++;
      if (done_at != W + 1) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", nm, done_at, W + 1);
      end
      checks++;
      if (busy_cnt != W) begin
         errors++;
         $display("FAIL %s busy_cycles got %0d want %0d", nm, busy_cnt, W);
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL %s done_pulses got %0d want 1", nm, n_done);
      end
      checks++;
      if ({c_at, s_at} !== r) begin
         errors++;
         $display("FAIL %s result got cout=%b sum=%h want cout=%b sum=%h",
                  nm, c_at, s_at, r[W], r[W-1:0]);
      end
      checks++;
      if (cells_at !== 3'b000) begin
         errors++;
         $display("FAIL %s cells_in_done got %b want 000", nm, cells_at);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (o_at !== exp_ovf) begin
         errors++;
         $display("FAIL %s ovf got %b want %b", nm, o_at, exp_ovf);
      end
`endif
      checks++;
      if ({cout, sum} !== r) begin
         errors++;
         $display("FAIL %s held_result got %h want %h", nm, {cout, sum}, r);
      end
   endtask

   task automatic test_directed();
      test_add(8'h01, 8'h01, 1'b0, "one_plus_one");
      test_add(8'hFF, 8'h01, 1'b0, "ff_plus_01");
      test_add(8'hFF, 8'h00, 1'b1, "ff_plus_cin");
      test_add(8'h7F, 8'h01, 1'b0, "ovf_pos");
      test_add(8'h80, 8'hFF, 1'b0, "ovf_neg");
      test_add(8'h10, 8'h20, 1'b0, "no_ovf");
      test_add(8'hFF, 8'hFF, 1'b1, "all_ones");
      test_add(8'h00, 8'h00, 1'b0, "zeros");
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++)
         test_add(W'($urandom), W'($urandom), 1'($urandom), "random");
   endtask

   task automatic test_ignore_start();
      logic [W:0] r;
      int n_done;
      logic [W:0] got;
      r = (W+1)'(8'h33) + (W+1)'(8'h44);
      got = '0; n_done = 0;
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 3) begin
            start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
         end else if (i == 4) begin
            start = 1'b0;
         end
         if (done) begin
            n_done++;
            got = {cout, sum};
         end
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL ignore_start done_pulses got %0d want 1", n_done);
      end
      checks++;
      if (got !== r) begin
         errors++;
         $display("FAIL ignore_start result got %h want %h", got, r);
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      n_done = 0;
      @(negedge clk);
      start = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 4; i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, cout, cell_a, cell_b, cell_c} !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs got busy=%b done=%b sum=%h cout=%b cells=%b%b%b want all 0",
                  busy, done, sum, cout, cell_a, cell_b, cell_c);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ovf got %b want 0", ovf);
      end
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL reset_mid activity_after_reset got %0d cycles want 0", n_done);
      end
      test_add(8'h05, 8'h03, 1'b0, "post_reset");
   endtask

   task automatic test_back_to_back();
      int pulses, bad_sum, bad_cells, bad_gap, last_at, waited;
      pulses = 0; bad_sum = 0; bad_cells = 0; bad_gap = 0; last_at = 0;
      @(negedge clk);
      start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
      @(posedge clk); #1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (i - last_at != W + 1) bad_gap++;
            last_at = i;
            if ({cout, sum} !== 9'h010) bad_sum++;
            if ({cell_a, cell_b, cell_c} !== 3'b000) bad_cells++;
         end
      end
      start = 1'b0;
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL b2b pulses got %0d want 4", pulses);
      end
      checks++;
      if (bad_gap != 0) begin
         errors++;
         $display("FAIL b2b spacing got %0d bad gaps want 0", bad_gap);
      end
      checks++;
      if (bad_sum != 0) begin
         errors++;
         $display("FAIL b2b sum got %0d wrong results want 0", bad_sum);
      end
      checks++;
      if (bad_cells != 0) begin
         errors++;
         $display("FAIL b2b cells_in_done got %0d nonzero want 0", bad_cells);
      end
      waited = 0;
      while ((busy || done) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (busy || done) begin
         errors++;
         $display("FAIL b2b drain busy=%b done=%b want idle", busy, done);
      end
   endtask

   task automatic test_width1();
      int done_at, busy_cnt, sv, sa;
      logic [1:0] got;
      logic exp_ovf, got_ovf;
      for (int v = 0; v < 8; v++) begin
         sv = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
         sa = -(v & 1) - ((v >> 1) & 1) + ((v >> 2) & 1);
         exp_ovf = (sa > 0) || (sa < -1);
         @(negedge clk);
         start1 = 1'b1; a1 = 1'(v); b1 = 1'(v >> 1); cin1 = 1'(v >> 2);
         @(posedge clk); #1;
         start1 = 1'b0;
         done_at = 0; busy_cnt = 0; got = '0; got_ovf = 1'b0;
         for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (busy1) busy_cnt++;
            if (done1 && done_at == 0) begin
               done_at = i;
               got = {cout1, sum1};
`ifdef SERIAL_ADD_OVF_EN
               got_ovf = ovf1;
`endif
            end
         end
         checks++;
         if (done_at != 2 || busy_cnt != 1) begin
            errors++;
            $display("FAIL w1_timing v=%0d got done_at=%0d busy=%0d want 2/1", v, done_at, busy_cnt);
         end
         checks++;
         if (got !== 2'(sv)) begin
            errors++;
            $display("FAIL w1_result v=%0d got %b want %b", v, got, 2'(sv));
         end
`ifdef SERIAL_ADD_OVF_EN
         checks++;
         if (got_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL w1_ovf v=%0d got %b want %b", v, got_ovf, exp_ovf);
         end
`else
         if (exp_ovf && got_ovf) got_ovf = 1'b0;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_width1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
